// File: rtl/ov5640_pkg.sv
// ============================================================================
// Module  : ov5640_pkg
// Brief   : Shared types and constants for the OV5640 bring-up sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ov5640_pkg;

    localparam int DEV_W = 8;
    localparam int REG_W = 16;
    localparam int DAT_W = 8;

    localparam logic [REG_W-1:0] SWRST_REG = 16'h3008;
    localparam logic [DAT_W-1:0] SWRST_VAL = 8'h82;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PWR_WAIT  = 4'd1,
        ST_LOAD      = 4'd2,
        ST_ISSUE     = 4'd3,
        ST_WAIT_DONE = 4'd4,
        ST_V_ISSUE   = 4'd5,
        ST_V_WAIT    = 4'd6,
        ST_GAP       = 4'd7,
        ST_FINISH    = 4'd8
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ov5640_cfg_rom.sv
// ============================================================================
// Module  : ov5640_cfg_rom
// Brief   : OV5640 init table, idx -> {reg_addr, wr_data}; entry 0 is soft reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ov5640_cfg_rom
    import ov5640_pkg::*;
(
    input  logic [7:0]             idx,
    output logic [REG_W+DAT_W-1:0] rom_data
);

    always_comb begin
        rom_data = 24'h3008_02;
        case (idx)
            8'd0:    rom_data = {SWRST_REG, SWRST_VAL};
            8'd1:    rom_data = 24'h3008_42;
            8'd2:    rom_data = 24'h3103_03;
            8'd3:    rom_data = 24'h3017_ff;
            8'd4:    rom_data = 24'h3018_ff;
            8'd5:    rom_data = 24'h3034_1a;
            8'd6:    rom_data = 24'h3037_13;
            8'd7:    rom_data = 24'h3108_01;
            8'd8:    rom_data = 24'h3630_36;
            8'd9:    rom_data = 24'h3631_0e;
            8'd10:   rom_data = 24'h3632_e2;
            8'd11:   rom_data = 24'h3633_12;
            8'd12:   rom_data = 24'h3621_e0;
            8'd13:   rom_data = 24'h3704_a0;
            8'd14:   rom_data = 24'h3703_5a;
            8'd15:   rom_data = 24'h3715_78;
            8'd16:   rom_data = 24'h3717_01;
            8'd17:   rom_data = 24'h370b_60;
            8'd18:   rom_data = 24'h3705_1a;
            8'd19:   rom_data = 24'h3905_02;
            8'd20:   rom_data = 24'h3906_10;
            8'd21:   rom_data = 24'h3901_0a;
            8'd22:   rom_data = 24'h3731_12;
            8'd23:   rom_data = 24'h3600_08;
            8'd24:   rom_data = 24'h3601_33;
            8'd25:   rom_data = 24'h302d_60;
            8'd26:   rom_data = 24'h3620_52;
            8'd27:   rom_data = 24'h371b_20;
            8'd28:   rom_data = 24'h471c_50;
            8'd29:   rom_data = 24'h3a13_43;
            8'd30:   rom_data = 24'h3a18_00;
            8'd31:   rom_data = 24'h3a19_f8;
            8'd32:   rom_data = 24'h3635_13;
            8'd33:   rom_data = 24'h3636_03;
            8'd34:   rom_data = 24'h3634_40;
            8'd35:   rom_data = 24'h3622_01;
            8'd36:   rom_data = 24'h3c01_34;
            8'd37:   rom_data = 24'h3c04_28;
            8'd38:   rom_data = 24'h3c05_98;
            8'd39:   rom_data = 24'h3c06_00;
            8'd40:   rom_data = 24'h3c07_08;
            8'd41:   rom_data = 24'h3c08_00;
            8'd42:   rom_data = 24'h3c09_1c;
            8'd43:   rom_data = 24'h3c0a_9c;
            8'd44:   rom_data = 24'h3c0b_40;
            8'd45:   rom_data = 24'h3820_41;
            8'd46:   rom_data = 24'h3821_07;
            8'd47:   rom_data = 24'h3814_31;
            8'd48:   rom_data = 24'h3815_31;
            8'd49:   rom_data = 24'h4300_61;
            8'd50:   rom_data = 24'h501f_01;
            // Entries past the populated table keep the sensor in normal operation.
            default: rom_data = 24'h3008_02;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ov5640_cfg_seq.sv
// ============================================================================
// Module  : ov5640_cfg_seq
// Brief   : OV5640 bring-up sequencer; walks the init table over ov5640_sccb.
//           Define OV5640_CFG_VERIFY_EN for read-back verify with retries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ov5640_cfg_seq
    import ov5640_pkg::*;
#(
    parameter logic [7:0] REG_NUM       = 8'd250,
    parameter int         PWR_DLY_CYC   = 2_000_000,
    parameter int         SWRST_DLY_CYC = 500_000,
    parameter int         GAP_CYC       = 100,
    parameter logic [7:0] DEV_ID        = 8'h78,
    parameter int         MAX_RETRY     = 3
) (
    input  logic                         sysclk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    output logic                         sccb_start,
    output logic [DEV_W+REG_W+DAT_W-1:0] sccb_cfg_data,
    input  logic                         sccb_done,
    input  logic                         sccb_busy,
    input  logic [DAT_W-1:0]             sccb_rd_data,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic [7:0]                   cfg_idx
);

    localparam int c_MAX_DLY = max3(PWR_DLY_CYC, SWRST_DLY_CYC, GAP_CYC);
    localparam int c_CNT_W   = $clog2(c_MAX_DLY + 1);

    localparam logic [c_CNT_W-1:0] c_PWR_LAST   = c_CNT_W'(PWR_DLY_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SWRST_LAST = c_CNT_W'(SWRST_DLY_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYC - 1);

    state_e                         r_state;
    state_e                         w_state_nxt;
    logic   [c_CNT_W-1:0]           r_cnt;
    logic   [7:0]                   r_idx;
    logic   [DEV_W+REG_W+DAT_W-1:0] r_cfg_data;
    logic                           r_done;
    logic   [REG_W+DAT_W-1:0]       w_rom_data;
    logic                           w_start;
    logic                           w_idx_last;
    logic   [c_CNT_W-1:0]           w_gap_last;
    logic                           w_gap_end;

    ov5640_cfg_rom u_rom (
        .idx      (r_idx),
        .rom_data (w_rom_data)
    );

    assign w_idx_last = (r_idx == (REG_NUM - 8'd1));
    assign w_gap_last = (r_idx == 8'd0) ? c_SWRST_LAST : c_GAP_LAST;
    assign w_gap_end  = (r_cnt == w_gap_last);

`ifdef OV5640_CFG_VERIFY_EN
    localparam int                 c_RTY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX = c_RTY_W'(MAX_RETRY);

    logic [c_RTY_W-1:0] r_retry;
    logic               r_err;
    logic               w_rd_match;

    // Read-back is compared against the ROM because r_cfg_data now holds the read word.
    assign w_rd_match = (sccb_rd_data == w_rom_data[DAT_W-1:0]);
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = ST_PWR_WAIT;
                end
            end
            ST_PWR_WAIT: begin
                if (r_cnt == c_PWR_LAST) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!sccb_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (sccb_done) begin
`ifdef OV5640_CFG_VERIFY_EN
                    // The soft-reset entry wipes the register file, so it is never read back.
                    w_state_nxt = (r_idx == 8'd0) ? ST_GAP : ST_V_ISSUE;
`else
                    w_state_nxt = ST_GAP;
`endif
                end
            end
`ifdef OV5640_CFG_VERIFY_EN
            ST_V_ISSUE: begin
                if (!sccb_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_V_WAIT;
                end
            end
            ST_V_WAIT: begin
                if (sccb_done) begin
                    if (w_rd_match) begin
                        w_state_nxt = ST_GAP;
                    end else if (r_retry == c_RTY_MAX) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
`endif
            ST_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = w_idx_last ? ST_FINISH : ST_LOAD;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= 8'd0;
            r_cfg_data <= '0;
            r_done     <= 1'b0;
        end else begin
            // The single delay counter restarts on every state change.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_PWR_WAIT) || (r_state == ST_GAP)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if ((r_state == ST_IDLE) && cfg_start) begin
                r_idx  <= 8'd0;
                r_done <= 1'b0;
            end

            if (r_state == ST_LOAD) begin
                r_cfg_data <= {DEV_ID, w_rom_data};
            end

            if ((r_state == ST_GAP) && w_gap_end && !w_idx_last) begin
                r_idx <= r_idx + 8'd1;
            end

            if (r_state == ST_FINISH) begin
                r_done <= 1'b1;
            end

`ifdef OV5640_CFG_VERIFY_EN
            if ((r_state == ST_WAIT_DONE) && sccb_done && (r_idx != 8'd0)) begin
                r_cfg_data <= {DEV_ID | 8'h01, r_cfg_data[DAT_W +: REG_W], {DAT_W{1'b0}}};
            end
`endif
        end
    end

`ifdef OV5640_CFG_VERIFY_EN
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && cfg_start) begin
                r_retry <= '0;
                r_err   <= 1'b0;
            end else if ((r_state == ST_GAP) && w_gap_end && !w_idx_last) begin
                r_retry <= '0;
            end else if ((r_state == ST_V_WAIT) && sccb_done && !w_rd_match) begin
                if (r_retry == c_RTY_MAX) begin
                    r_err <= 1'b1;
                end else begin
                    r_retry <= r_retry + c_RTY_W'(1);
                end
            end
        end
    end

    assign cfg_err = r_err;
`else
    logic w_unused;
    assign w_unused = ^{sccb_rd_data, 8'(MAX_RETRY)};
    assign cfg_err  = 1'b0;
`endif

    assign sccb_start    = w_start;
    assign sccb_cfg_data = r_cfg_data;
    assign cfg_busy      = (r_state != ST_IDLE);
    assign cfg_done      = r_done;
    assign cfg_idx       = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_ov5640_cfg_seq.sv
// ============================================================================
// Module  : tb_ov5640_cfg_seq
// Brief   : Bench for ov5640_cfg_seq with a behavioural SCCB slave model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov5640_cfg_seq;

    localparam int c_LAT = 30;
    localparam int c_LOG = 128;

    typedef struct {
        int          entry;
        logic [31:0] word;
    } vec_t;

    logic        sysclk    = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cfg_start = 1'b0;
    logic        sccb_start;
    logic [31:0] sccb_cfg_data;
    logic        sccb_done;
    logic        sccb_busy;
    logic [7:0]  sccb_rd_data;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  cfg_idx;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_is_rd = 1'b0;
    logic [15:0] m_reg = 16'h0;
    logic [7:0]  m_rd = 8'h00;
    logic [7:0]  m_last_wr = 8'h00;
    int          m_cnt = 0;
    int          m_bad_seen = 0;
    logic        stray_done = 1'b0;

    int          corrupt_n = 0;
    logic [15:0] corrupt_reg = 16'h0;
    logic        zero_en = 1'b0;
    logic [15:0] zero_reg = 16'h0;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] log_word [c_LOG];
    int          log_start [c_LOG];
    int          log_done [c_LOG];
    int          n_start = 0;
    int          n_done = 0;

    assign sccb_done    = m_done | stray_done;
    assign sccb_busy    = m_busy;
    assign sccb_rd_data = m_rd;

    ov5640_cfg_seq #(
        .REG_NUM       (8'd4),
        .PWR_DLY_CYC   (50),
        .SWRST_DLY_CYC (20),
        .GAP_CYC       (4),
        .DEV_ID        (8'h78),
        .MAX_RETRY     (3)
    ) dut (
        .sysclk        (sysclk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .sccb_start    (sccb_start),
        .sccb_cfg_data (sccb_cfg_data),
        .sccb_done     (sccb_done),
        .sccb_busy     (sccb_busy),
        .sccb_rd_data  (sccb_rd_data),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .cfg_idx       (cfg_idx)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // SCCB slave: done pulse c_LAT cycles after start; reads echo the last write.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_done     <= 1'b0;
            m_cnt      <= 0;
            m_rd       <= 8'h00;
            m_bad_seen <= 0;
        end else begin
            m_done <= 1'b0;
            if (sccb_start && !m_busy) begin
                m_busy  <= 1'b1;
                m_cnt   <= 1;
                m_reg   <= sccb_cfg_data[23:8];
                m_is_rd <= sccb_cfg_data[24];
                if (!sccb_cfg_data[24]) m_last_wr <= sccb_cfg_data[7:0];
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == c_LAT - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    if (m_is_rd) begin
                        if (zero_en && (m_reg == zero_reg)) begin
                            m_rd <= 8'h00;
                        end else if ((m_reg == corrupt_reg) && (m_bad_seen < corrupt_n)) begin
                            m_rd       <= ~m_last_wr;
                            m_bad_seen <= m_bad_seen + 1;
                        end else begin
                            m_rd <= m_last_wr;
                        end
                    end
                end
            end
        end
    end

    always @(negedge sysclk) begin
        if (sccb_start && (n_start < c_LOG)) begin
            log_word[n_start]  = sccb_cfg_data;
            log_start[n_start] = cyc;
            n_start            = n_start + 1;
        end
        if (m_done && (n_done < c_LOG)) begin
            log_done[n_done] = cyc;
            n_done           = n_done + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start(output int c0);
        c0        = cyc;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int k;
        k = 0;
        while (!((cfg_done || cfg_err) && !cfg_busy) && (k < 3000)) begin
            step();
            k++;
        end
        if (k >= 3000) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_txn(input logic [7:0] idx, input string name);
        int k;
        k = 0;
        while (!((cfg_idx == idx) && m_busy && cfg_busy) && (k < 3000)) begin
            step();
            k++;
        end
        if (k >= 3000) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int count_word(input int from, input int upto, input logic [31:0] w);
        int n;
        n = 0;
        for (int i = from; i < upto; i++) begin
            if (log_word[i] == w) n++;
        end
        return n;
    endfunction

    initial begin
        vec_t exp_tab[$];
        int   c0;
        int   b;
        int   bd;

`ifdef OV5640_CFG_VERIFY_EN
        exp_tab.push_back('{0, 32'h7830_0882});
        exp_tab.push_back('{1, 32'h7830_0842});
        exp_tab.push_back('{1, 32'h7930_0800});
        exp_tab.push_back('{2, 32'h7831_0303});
        exp_tab.push_back('{2, 32'h7931_0300});
        exp_tab.push_back('{3, 32'h7830_17ff});
        exp_tab.push_back('{3, 32'h7930_1700});
`else
        exp_tab.push_back('{0, 32'h7830_0882});
        exp_tab.push_back('{1, 32'h7830_0842});
        exp_tab.push_back('{2, 32'h7831_0303});
        exp_tab.push_back('{3, 32'h7830_17ff});
`endif

        // Reset state
        do_reset();
        chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
        chk("rst_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_idx", {24'd0, cfg_idx}, 32'd0);
        chk("rst_start", {31'd0, sccb_start}, 32'd0);
        chk("rst_data", sccb_cfg_data, 32'd0);

        // Basic sequence, table order and gap timing
        b  = n_start;
        bd = n_done;
        pulse_start(c0);
        chk("busy_after_start", {31'd0, cfg_busy}, 32'd1);
        wait_end("basic");
        chk("basic_count", n_start - b, exp_tab.size());
        for (int i = 0; i < exp_tab.size(); i++) begin
            chk($sformatf("basic_word%0d_entry%0d", i, exp_tab[i].entry), log_word[b + i], exp_tab[i].word);
        end
        chk("first_lat_ge52", {31'd0, (log_start[b] - c0) >= 52}, 32'd1);
        chk("swrst_gap", log_start[b + 1] - log_done[bd] - 1, 32'd21);
`ifdef OV5640_CFG_VERIFY_EN
        chk("normal_gap", log_start[b + 3] - log_done[bd + 2] - 1, 32'd5);
`else
        chk("normal_gap", log_start[b + 2] - log_done[bd + 1] - 1, 32'd5);
`endif
        chk("basic_done", {31'd0, cfg_done}, 32'd1);
        chk("basic_err", {31'd0, cfg_err}, 32'd0);
        chk("basic_idx", {24'd0, cfg_idx}, 32'd3);
        chk("basic_busy", {31'd0, cfg_busy}, 32'd0);

        // Start while busy, plus a stray done during the power-up wait
        do_reset();
        b = n_start;
        pulse_start(c0);
        repeat (10) step();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        chk("stray_no_txn", n_start - b, 32'd0);
        wait_txn(8'd2, "busy_wait2");
        pulse_start(c0);
        chk("busy_idx_hold", {24'd0, cfg_idx}, 32'd2);
        wait_end("busy");
        chk("busy_count", n_start - b, exp_tab.size());
        chk("busy_last_word", log_word[b + exp_tab.size() - 1], exp_tab[exp_tab.size() - 1].word);
        chk("busy_idx_end", {24'd0, cfg_idx}, 32'd3);
        chk("busy_done", {31'd0, cfg_done}, 32'd1);

        // Reset in the middle of entry 1
        do_reset();
        pulse_start(c0);
        wait_txn(8'd1, "rst_wait1");
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, cfg_busy}, 32'd0);
        chk("midrst_data", sccb_cfg_data, 32'd0);
        chk("midrst_idx", {24'd0, cfg_idx}, 32'd0);
        chk("midrst_start", {31'd0, sccb_start}, 32'd0);
        chk("midrst_done", {31'd0, cfg_done}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        b = n_start;
        pulse_start(c0);
        wait_end("replay");
        chk("replay_count", n_start - b, exp_tab.size());
        chk("replay_first", log_word[b], 32'h7830_0882);
        chk("replay_done", {31'd0, cfg_done}, 32'd1);

`ifdef OV5640_CFG_VERIFY_EN
        // Entry 2 read back wrong twice, then correct
        corrupt_reg = 16'h3103;
        corrupt_n   = 2;
        do_reset();
        b = n_start;
        pulse_start(c0);
        wait_end("retry");
        chk("retry_writes", count_word(b, n_start, 32'h7831_0303), 32'd3);
        chk("retry_reads", count_word(b, n_start, 32'h7931_0300), 32'd3);
        chk("retry_count", n_start - b, 32'd11);
        chk("retry_done", {31'd0, cfg_done}, 32'd1);
        chk("retry_err", {31'd0, cfg_err}, 32'd0);

        // Entry 1 always reads back zero
        corrupt_n = 0;
        zero_reg  = 16'h3008;
        zero_en   = 1'b1;
        do_reset();
        b = n_start;
        pulse_start(c0);
        wait_end("vfail");
        chk("vfail_writes", count_word(b, n_start, 32'h7830_0842), 32'd4);
        chk("vfail_reads", count_word(b, n_start, 32'h7930_0800), 32'd4);
        chk("vfail_err", {31'd0, cfg_err}, 32'd1);
        chk("vfail_done", {31'd0, cfg_done}, 32'd0);
        chk("vfail_idx", {24'd0, cfg_idx}, 32'd1);
        chk("vfail_busy", {31'd0, cfg_busy}, 32'd0);

        zero_en = 1'b0;
        pulse_start(c0);
        chk("recover_err_clr", {31'd0, cfg_err}, 32'd0);
        wait_end("recover");
        chk("recover_done", {31'd0, cfg_done}, 32'd1);
        chk("recover_err", {31'd0, cfg_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
- Sequencer that brings up the OV5640 by walking a register table and driving ov5640_sccb one transaction at a time.
- Sequence: power-up wait, then table entries in order, with an extra delay after the software-reset entry and a gap between transactions.
- Sits between the top-level/ISP enable logic and ov5640_sccb, and is the only master of that port.

Parameters:
- REG_NUM, 8'd250: number of table entries, valid range 1..255.
- PWR_DLY_CYC, 2_000_000: sysclk cycles waited after cfg_start before the first transaction (20 ms at 100 MHz).
- SWRST_DLY_CYC, 500_000: extra wait after entry 0 (0x3008 = 0x82 soft reset).
- GAP_CYC, 100: idle sysclk cycles between consecutive transactions; minimum 1.
- DEV_ID, 8'h78: SCCB write device address; the read address is DEV_ID|1.
- MAX_RETRY, 3: retries per entry (verify mode only).

Ports:
- sysclk, in, 1: system clock, same clock as ov5640_sccb.
- rst_n, in, 1: asynchronous active-low reset.
- cfg_start, in, 1: one-cycle pulse that starts the full sequence; ignored while cfg_busy=1.
- sccb_start, out, 1: one-cycle start pulse to ov5640_sccb.
- sccb_cfg_data, out, 32: {dev_addr[7:0], reg_addr[15:0], wr_data[7:0]}; dev_addr bit0 = 1 means read.
- sccb_done, in, 1: one-cycle transaction-complete pulse from ov5640_sccb.
- sccb_busy, in, 1: ov5640_sccb busy.
- sccb_rd_data, in, 8: read data, valid at sccb_done of a read.
- cfg_busy, out, 1: sequence in progress.
- cfg_done, out, 1: level; set when the whole table completes, cleared on the next cfg_start.
- cfg_err, out, 1: level; set on verify failure, cleared on the next cfg_start.
- cfg_idx, out, 8: index of the current or last entry (debug).

Behaviour:
- Reset: every output is 0; FSM in IDLE; all counters 0.
- States and transitions:
  - IDLE: on cfg_start, clear cfg_done/cfg_err, set idx=0, go to PWR_WAIT.
  - PWR_WAIT: count PWR_DLY_CYC cycles, then go to LOAD.
  - LOAD: one cycle; latch the ROM word for idx into sccb_cfg_data[23:0], and DEV_ID into [31:24].
  - ISSUE: wait until sccb_busy=0, then assert sccb_start for exactly 1 cycle and go to WAIT_DONE.
  - WAIT_DONE: wait for sccb_done. No timeout.
  - GAP: count GAP_CYC cycles, or SWRST_DLY_CYC instead when idx==0. Then, if idx==REG_NUM-1, go to FINISH; else idx++ and go to LOAD.
  - FINISH: set cfg_done=1, cfg_busy=0, return to IDLE.
- cfg_busy = 1 in every state except IDLE.
- sccb_cfg_data holds stable from LOAD until the next LOAD.
- Latency: the first sccb_start comes at least PWR_DLY_CYC+2 cycles after cfg_start.
- Counters are sized to hold the largest delay parameter; each counter reloads on state entry.
- Boundary conditions:
  - sccb_done outside WAIT_DONE is ignored.
  - cfg_start while busy is ignored; the sequence does not restart.
  - rst_n asserted mid-transaction returns to IDLE immediately; the SCCB slave is reset by the same rst_n.
  - REG_NUM=1: entry 0 runs, then SWRST gap, then FINISH.
  - idx never exceeds REG_NUM-1, and the table address never wraps.

Optional Feature:
- Macro: OV5640_CFG_VERIFY_EN.
- Defined:
  - After the write's sccb_done, go to V_ISSUE: issue a read with sccb_cfg_data={DEV_ID|1, reg_addr, 8'h00}.
  - In V_WAIT, on sccb_done compare sccb_rd_data with wr_data.
  - Match: go to GAP.
  - Mismatch: retry_cnt++ and go to LOAD (rewrite the same entry).
  - Mismatch with retry_cnt==MAX_RETRY: set cfg_err=1, cfg_busy=0, go to IDLE; cfg_done stays 0.
  - Entry 0 (soft reset) is never verified.
  - retry_cnt clears on each idx advance.
- Undefined: no read transactions; cfg_err is tied to 0.

Decomposition:
- Package ov5640_pkg holds:
  - state enum;
  - field widths DEV_W=8, REG_W=16, DAT_W=8;
  - constants SWRST_REG=16'h3008 and SWRST_VAL=8'h82.
- One sub-module, ov5640_cfg_rom: combinational case table, idx[7:0] -> {reg_addr, wr_data}[23:0]; entry 0 is fixed to {SWRST_REG, SWRST_VAL}.

Test Plan:
- Simulation settings: PWR_DLY_CYC=50, SWRST_DLY_CYC=20, GAP_CYC=4, REG_NUM=4. Behavioural SCCB model returns sccb_done 30 cycles after sccb_start and echoes written data on reads.
- Basic sequence: cfg_start -> first sccb_start at ≥52 cycles with sccb_cfg_data=32'h78300882; exactly 4 start pulses in table order; cfg_done=1 after the last gap; cfg_err=0.
- Software-reset gap: measured gap between done#0 and start#1 is 20+1 cycles; gaps between later transactions are 4+1 cycles.
- Start while busy: cfg_start pulsed during WAIT_DONE of entry 2 -> ignored; idx continues 2→3; still exactly 4 transactions.
- Reset mid-sequence: rst_n low during entry 1 -> all outputs 0 within the same cycle; a following cfg_start replays from idx 0.
- Verify mode (OV5640_CFG_VERIFY_EN): model corrupts the read of entry 2 twice, then echoes correctly -> 3 writes and 3 reads for entry 2; cfg_done=1, cfg_err=0.
- Verify failure (OV5640_CFG_VERIFY_EN): model always returns 8'h00 for entry 1 -> 4 write/read pairs (1 + MAX_RETRY); cfg_err=1, cfg_done=0, cfg_idx=1, returns to IDLE.
